// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus a 16-byte MMIO window (timer, compare, status, LEDs).
// Optional TIMER_AUTORELOAD_EN: COUNT reloads 0 on compare match instead of incrementing.
module data_mem_mmio #(
  parameter int          DEPTH     = 64,
  parameter int          LED_W     = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      r_ram [DEPTH];
  logic [31:0]      r_count;
  logic [31:0]      r_cmp;
  logic [2:0]       r_status;
  logic [LED_W-1:0] r_led;

  logic          w_aligned;
  logic          w_isRam;
  logic          w_isMmio;
  logic          w_ramWe;
  logic          w_mmioWe;
  logic          w_match;
  logic [AW-1:0] w_idx;
  logic [2:0]    w_set;
  logic [2:0]    w_clr;
  logic [31:0]   w_ledExt;

  // RAM takes priority so the decode stays unambiguous for any parameter choice
  assign w_aligned = (addr[1:0] == 2'b00);
  assign w_isRam   = (addr[31:AW+2] == '0);
  assign w_isMmio  = (addr[31:4] == MMIO_BASE[31:4]);
  assign w_idx     = addr[AW+1:2];
  assign w_ramWe   = memwrite & w_aligned & w_isRam;
  assign w_mmioWe  = memwrite & w_aligned & ~w_isRam & w_isMmio;
  assign w_match   = (r_count == r_cmp);

  assign w_set = {memwrite & w_aligned & ~w_isRam & ~w_isMmio,
                  memwrite & ~w_aligned,
                  w_match};
  assign w_clr = (w_mmioWe && addr[3:2] == 2'd2) ? writedata[2:0] : 3'b000;

  always_comb begin
    w_ledExt             = '0;
    w_ledExt[LED_W-1:0]  = r_led;
  end

  always_comb begin
    readdata = '0;
    if (w_aligned) begin
      if (w_isRam) begin
        readdata = r_ram[w_idx];
      end else if (w_isMmio) begin
        case (addr[3:2])
          2'd0:    readdata = r_count;
          2'd1:    readdata = r_cmp;
          2'd2:    readdata = {29'b0, r_status};
          default: readdata = w_ledExt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_ram[w_idx] <= writedata;
    end
  end

  // Set beats W1C clear when both hit the same status bit on one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_cmp    <= 32'hFFFFFFFF;
      r_status <= '0;
      r_led    <= '0;
    end else begin
      if (w_mmioWe && addr[3:2] == 2'd0) begin
        r_count <= writedata;
`ifdef TIMER_AUTORELOAD_EN
      end else if (w_match) begin
        r_count <= '0;
`endif
      end else begin
        r_count <= r_count + 32'd1;
      end
      if (w_mmioWe && addr[3:2] == 2'd1) begin
        r_cmp <= writedata;
      end
      if (w_mmioWe && addr[3:2] == 2'd3) begin
        r_led <= writedata[LED_W-1:0];
      end
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  assign leds = r_led;
  assign irq  = r_status[0];

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed scenarios plus randomized traffic
// checked against a behavioural model of the memory map and timer.
module tb_data_mem_mmio;

  localparam int          DEPTH = 64;
  localparam int          LED_W = 8;
  localparam logic [31:0] BASE  = 32'hFFFF0000;
  localparam logic [31:0] CNTA  = BASE;
  localparam logic [31:0] CMPA  = BASE + 32'd4;
  localparam logic [31:0] STA   = BASE + 32'd8;
  localparam logic [31:0] LEDA  = BASE + 32'd12;
  localparam logic [31:0] LEDMASK = (32'd1 << LED_W) - 32'd1;
`ifdef TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             memwrite = 1'b0;
  logic [31:0]      addr = '0;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [LED_W-1:0] leds;
  logic             irq;

  int nChecks = 0;
  int nFails  = 0;

  logic [31:0] mCount, mCmp, mLed;
  logic [2:0]  mStatus;
  logic [31:0] mRam [int];

  always #5 clk = ~clk;

  data_mem_mmio #(.DEPTH(DEPTH), .LED_W(LED_W), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .leds(leds), .irq(irq)
  );

  // Reference model: memory map and timer rules applied once per clock edge
  task automatic modelReset();
    mCount  = '0;
    mCmp    = 32'hFFFFFFFF;
    mStatus = '0;
    mLed    = '0;
  endtask

  task automatic modelRead(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v     = '0;
    if (a[1:0] != 2'b00) v = '0;
    else if (a < 32'(DEPTH * 4)) begin
      if (mRam.exists(int'(a / 4))) v = mRam[int'(a / 4)];
      else known = 1'b0;
    end else if (a[31:4] == BASE[31:4]) begin
      case (a[3:0])
        4'h0:    v = mCount;
        4'h4:    v = mCmp;
        4'h8:    v = {29'b0, mStatus};
        default: v = mLed;
      endcase
    end
  endtask

  task automatic modelEdge(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit al, ram, mm, hit;
    logic [2:0] set, clr;
    al  = (a[1:0] == 2'b00);
    ram = (a < 32'(DEPTH * 4));
    mm  = (a[31:4] == BASE[31:4]);
    hit = (mCount == mCmp);
    set = {we && al && !ram && !mm, we && !al, hit};
    clr = (we && al && !ram && mm && a[3:0] == 4'h8) ? d[2:0] : 3'b000;
    if (we && al && ram) mRam[int'(a / 4)] = d;
    if (we && al && !ram && mm && a[3:0] == 4'h0) mCount = d;
    else if (AR && hit) mCount = '0;
    else mCount = mCount + 32'd1;
    if (we && al && !ram && mm && a[3:0] == 4'h4) mCmp = d;
    if (we && al && !ram && mm && a[3:0] == 4'hC) mLed = d & LEDMASK;
    mStatus = (mStatus & ~clr) | set;
  endtask

  // One bus cycle: drive after an edge, sample readdata at negedge, settle past the next edge
  task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd);
    memwrite  = we;
    addr      = a;
    writedata = d;
    @(negedge clk);
    rd = readdata;
    @(posedge clk);
    modelEdge(we, a, d);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b0;
    memwrite = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    #1;
    nChecks++;
    if (leds !== '0) begin nFails++; $display("[TB] FAIL reset_leds got %h want 0", leds); end
    nChecks++;
    if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
    @(posedge clk);
    modelEdge(1'b0, addr, writedata);
    #1;
    applyStimulus(1'b0, STA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL reset_status got %h want 0", rd); end
    applyStimulus(1'b0, CMPA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hFFFFFFFF) begin nFails++; $display("[TB] FAIL reset_cmp got %h want ffffffff", rd); end
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    applyStimulus(1'b1, 32'h14, 32'h12345678, rd);
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, rd);
    applyStimulus(1'b0, 32'h10, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL ram_rd10 got %h want deadbeef", rd); end
    applyStimulus(1'b0, 32'h14, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h12345678) begin nFails++; $display("[TB] FAIL ram_rd14 got %h want 12345678", rd); end
    applyStimulus(1'b0, 32'h11, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL ram_misload got %h want 0", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    applyStimulus(1'b1, 32'h0, 32'hA0A0A0A0, rd);
    applyStimulus(1'b1, 32'h13, 32'h11111111, rd);
    applyStimulus(1'b1, 32'h1000, 32'h22222222, rd);
    applyStimulus(1'b0, STA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h6) begin nFails++; $display("[TB] FAIL err_status got %h want 6", rd); end
    applyStimulus(1'b0, 32'h10, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL err_ram10 got %h want deadbeef", rd); end
    applyStimulus(1'b0, 32'h0, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hA0A0A0A0) begin nFails++; $display("[TB] FAIL err_ram0 got %h want a0a0a0a0", rd); end
    applyStimulus(1'b1, STA, 32'h6, rd);
    applyStimulus(1'b0, STA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL err_w1c got %h want 0", rd); end
  endtask

  task automatic test_timer();
    logic [31:0] rd;
    applyStimulus(1'b1, CMPA, 32'd5, rd);
    applyStimulus(1'b1, CNTA, 32'd0, rd);
    applyStimulus(1'b1, STA, 32'd1, rd);
    nChecks++;
    if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL timer_clr got %b want 0", irq); end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, CNTA, 32'h0, rd);
      nChecks++;
      if (rd !== 32'(i)) begin nFails++; $display("[TB] FAIL timer_cnt%0d got %h want %h", i, rd, i); end
      nChecks++;
      if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL timer_early%0d got %b want 0", i, irq); end
    end
    applyStimulus(1'b1, STA, 32'd1, rd);
    nChecks++;
    if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL timer_setwins got %b want 1", irq); end
    applyStimulus(1'b0, CNTA, 32'h0, rd);
    nChecks++;
    if (rd !== (AR ? 32'd0 : 32'd6)) begin nFails++; $display("[TB] FAIL timer_after got %h want %h", rd, AR ? 32'd0 : 32'd6); end
    nChecks++;
    if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL timer_sticky got %b want 1", irq); end
    applyStimulus(1'b1, STA, 32'd1, rd);
    nChecks++;
    if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL timer_w1c got %b want 0", irq); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, STA, 32'h0, rd);
      nChecks++;
      if (irq !== (AR && i == 3)) begin nFails++; $display("[TB] FAIL timer_period%0d got %b want %b", i, irq, AR && i == 3); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    applyStimulus(1'b1, CNTA, 32'hFFFFFFF0, rd);
    applyStimulus(1'b1, STA, 32'd1, rd);
    applyStimulus(1'b1, CNTA, 32'hFFFFFFFE, rd);
    applyStimulus(1'b0, CNTA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hFFFFFFFE) begin nFails++; $display("[TB] FAIL wrap_fe got %h want fffffffe", rd); end
    applyStimulus(1'b0, CNTA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hFFFFFFFF) begin nFails++; $display("[TB] FAIL wrap_ff got %h want ffffffff", rd); end
    applyStimulus(1'b0, CNTA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_zero got %h want 0", rd); end
    applyStimulus(1'b0, STA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_status got %h want 0", rd); end
  endtask

  task automatic test_led_reset();
    logic [31:0] rd;
    applyStimulus(1'b1, LEDA, 32'h1A5, rd);
    nChecks++;
    if (leds !== 8'hA5) begin nFails++; $display("[TB] FAIL led_out got %h want a5", leds); end
    applyStimulus(1'b0, LEDA, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hA5) begin nFails++; $display("[TB] FAIL led_read got %h want a5", rd); end
    addr = LEDA;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    nChecks++;
    if (leds !== '0) begin nFails++; $display("[TB] FAIL midreset_leds got %h want 0", leds); end
    nChecks++;
    if (readdata !== 32'h0) begin nFails++; $display("[TB] FAIL midreset_read got %h want 0", readdata); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    modelEdge(1'b0, addr, writedata);
    #1;
    applyStimulus(1'b0, 32'h10, 32'h0, rd);
    nChecks++;
    if (rd !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL midreset_ram got %h want deadbeef", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp;
    bit we, known;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        4:          a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(1, 3));
        5, 6, 7:    a = BASE + 32'($urandom_range(0, 3)) * 32'd4;
        8:          a = BASE + 32'($urandom_range(0, 15)) | 32'd1;
        default:    a = 32'h00010000 + 32'($urandom_range(0, 4095)) * 32'd4;
      endcase
      we = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      if (a == CNTA) d = mCmp - 32'($urandom_range(0, 4));
      if (a == CMPA) d = 32'($urandom_range(0, 40));
      modelRead(a, exp, known);
      applyStimulus(we, a, d, rd);
      if (known) begin
        nChecks++;
        if (rd !== exp) begin nFails++; $display("[TB] FAIL rnd_read @%h got %h want %h", a, rd, exp); end
      end
      nChecks++;
      if (irq !== mStatus[0]) begin nFails++; $display("[TB] FAIL rnd_irq got %b want %b", irq, mStatus[0]); end
      nChecks++;
      if (leds !== mLed[LED_W-1:0]) begin nFails++; $display("[TB] FAIL rnd_leds got %h want %h", leds, mLed[LED_W-1:0]); end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_ram();
    test_errors();
    test_timer();
    test_wrap();
    test_led_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
